mult_div_unit: RTL and testbench

//   Multicycle signed multiply/divide unit for the MIPS datapath (MULT/DIV).

---
 rtl/mult_div_unit.sv | 166 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) unit writing HI/LO.
// One iteration per clock; results land WIDTH edges after an accepted start.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int unsigned ACC_W = 2 * WIDTH + 1;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               dz_pend_q;
    logic [ACC_W-1:0]   acc_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   dmag_q;
    logic               neg_q_q;
    logic               neg_r_q;

    logic               last_iter;
    logic               accept_mult;
    logic               accept_div;
    logic               div_by_zero;

    assign last_iter   = (cnt_q == CNT_W'(WIDTH - 1));
    assign accept_mult = (state_q == IDLE) && !dz_pend_q && start_mult;
    assign accept_div  = (state_q == IDLE) && !dz_pend_q && !start_mult && start_div;
    assign div_by_zero = (op_b == '0);

    // Booth step: add/sub in WIDTH+1 bits so a most-negative multiplicand cannot overflow
    logic [WIDTH:0]     hi_ext;
    logic [WIDTH:0]     mc_ext;
    logic [WIDTH:0]     booth_sum;
    logic [ACC_W-1:0]   acc_next;

    always_comb begin
        hi_ext = {acc_q[ACC_W-1], acc_q[ACC_W-1 -: WIDTH]};
        mc_ext = {mcand_q[WIDTH-1], mcand_q};
        case (acc_q[1:0])
            2'b01:   booth_sum = hi_ext + mc_ext;
            2'b10:   booth_sum = hi_ext - mc_ext;
            default: booth_sum = hi_ext;
        endcase
        acc_next = {booth_sum, acc_q[WIDTH:1]};
    end

    // Restoring divide step on magnitudes, plus sign fixup used on the final edge
    logic [WIDTH:0]     r_shift;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        r_shift  = {rem_q, quo_q[WIDTH-1]};
        trial    = r_shift - {1'b0, dmag_q};
        rem_next = trial[WIDTH] ? r_shift[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_next = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        quo_fix  = neg_q_q ? (WIDTH'(0) - quo_next) : quo_next;
        rem_fix  = neg_r_q ? (WIDTH'(0) - rem_next) : rem_next;
    end

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (WIDTH'(0) - v) : v;
    endfunction

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; a zero-divisor start takes one idle cycle before DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (dz_pend_q)                      state_d = DONE;
                else if (accept_mult)               state_d = MULT;
                else if (accept_div && !div_by_zero) state_d = DIV;
            end
            MULT:    if (last_iter) state_d = DONE;
            DIV:     if (last_iter) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            dz_pend_q <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dmag_q    <= '0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            hi_out    <= '0;
            lo_out    <= '0;
        end else begin
            busy      <= (state_d == MULT) || (state_d == DIV);
            done      <= (state_d == DONE);
            dz_pend_q <= accept_div && div_by_zero;

            if (accept_mult || accept_div) begin
                cnt_q    <= '0;
                div_zero <= accept_div && div_by_zero;
            end

            if (accept_mult) begin
                acc_q   <= {WIDTH'(0), op_b, 1'b0};
                mcand_q <= op_a;
            end

            if (accept_div) begin
                rem_q   <= '0;
                quo_q   <= mag(op_a);
                dmag_q  <= mag(op_b);
                neg_q_q <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                neg_r_q <= op_a[WIDTH-1];
            end

            if (state_q == MULT) begin
                acc_q <= acc_next;
                cnt_q <= cnt_q + CNT_W'(1);
                if (last_iter) begin
                    hi_out <= acc_next[ACC_W-1 -: WIDTH];
                    lo_out <= acc_next[WIDTH:1];
                end
            end

            if (state_q == DIV) begin
                rem_q <= rem_next;
                quo_q <= quo_next;
                cnt_q <= cnt_q + CNT_W'(1);
                if (last_iter) begin
                    hi_out <= rem_fix;
                    lo_out <= quo_fix;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: products, quotients, div-by-zero,
// ignored starts, start priority and mid-operation reset.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start_mult;
    logic        start_div;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int n_checks = 0;
    int n_fail   = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .hi_out     (hi_out),
        .lo_out     (lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one start, optionally pulse start_div at cycle glitch_at, wait for done.
    task automatic run_op(input logic do_mult, input logic do_div,
                          input logic [31:0] a, input logic [31:0] b,
                          input int glitch_at, output int lat, output logic busy_k);
        @(negedge clk);
        start_mult = do_mult;
        start_div  = do_div;
        op_a       = a;
        op_b       = b;
        @(posedge clk);
        @(negedge clk);
        busy_k     = busy;
        start_mult = 1'b0;
        start_div  = 1'b0;
        op_a       = $urandom;
        op_b       = $urandom;
        lat        = -1;
        for (int n = 1; n <= 100; n++) begin
            start_div = (n == glitch_at);
            @(negedge clk);
            start_div = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    int   lat;
    logic bk;

    initial begin
        reset      = 1'b0;
        start_mult = 1'b0;
        start_div  = 1'b0;
        op_a       = '0;
        op_b       = '0;
        repeat (2) @(negedge clk);
        check_eq("reset_outputs", {27'd0, busy, done, div_zero, 2'b00},   64'd0);
        check_eq("reset_hilo",    {hi_out, lo_out},                        64'd0);
        reset = 1'b1;

        // 7 x -3
        run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 0, lat, bk);
        check_eq("mult1_busy",    64'(bk),               64'd1);
        check_eq("mult1_latency", 64'(lat),              64'd32);
        check_eq("mult1_hilo",    {hi_out, lo_out},      64'hFFFF_FFFF_FFFF_FFEB);
        @(negedge clk);
        check_eq("mult1_done_pulse", {62'd0, done, busy}, 64'd0);

        // divide by zero keeps HI/LO
        run_op(1'b0, 1'b1, 32'd5, 32'd0, 0, lat, bk);
        check_eq("dz_latency", 64'(lat),          64'd1);
        check_eq("dz_flag",    64'(div_zero),     64'd1);
        check_eq("dz_hilo",    {hi_out, lo_out},  64'hFFFF_FFFF_FFFF_FFEB);

        // most-negative squared clears div_zero
        run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 0, lat, bk);
        check_eq("dz_cleared",   64'(div_zero),    64'd0);
        check_eq("mult_minsq",   {hi_out, lo_out}, 64'h4000_0000_0000_0000);
        run_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, lat, bk);
        check_eq("mult_maxsq",   {hi_out, lo_out}, 64'h3FFF_FFFF_0000_0001);
        run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, bk);
        check_eq("mult_m1m1",    {hi_out, lo_out}, 64'h0000_0000_0000_0001);

        // signed divides
        run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, lat, bk);
        check_eq("div_latency",  64'(lat),         64'd32);
        check_eq("div_m7_2",     {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, 0, lat, bk);
        check_eq("div_7_m2",     {hi_out, lo_out}, 64'h0000_0001_FFFF_FFFD);
        run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, bk);
        check_eq("div_min_m1",   {hi_out, lo_out}, 64'h0000_0000_8000_0000);
        run_op(1'b0, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 0, lat, bk);
        check_eq("div_m100_m7",  {hi_out, lo_out}, 64'hFFFF_FFFE_0000_000E);

        // start_div pulsed mid-MULT is ignored
        run_op(1'b1, 1'b0, 32'd12345, 32'd1000, 10, lat, bk);
        check_eq("glitch_latency", 64'(lat),          64'd32);
        check_eq("glitch_hilo",    {hi_out, lo_out},  64'h0000_0000_00BC_5EA8);
        @(negedge clk);
        check_eq("glitch_idle",    {62'd0, done, busy}, 64'd0);

        // both starts together: multiply wins
        run_op(1'b1, 1'b1, 32'd6, 32'd7, 0, lat, bk);
        check_eq("both_latency", 64'(lat),         64'd32);
        check_eq("both_hilo",    {hi_out, lo_out}, 64'd42);

        // reset during a divide
        @(negedge clk);
        start_div = 1'b1;
        op_a      = 32'd1000;
        op_b      = 32'd3;
        @(negedge clk);
        start_div = 1'b0;
        repeat (14) @(negedge clk);
        check_eq("pre_reset_busy", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        check_eq("midreset_flags", {61'd0, busy, done, div_zero}, 64'd0);
        check_eq("midreset_hilo",  {hi_out, lo_out},              64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op(1'b0, 1'b1, 32'd100, 32'd7, 0, lat, bk);
        check_eq("post_reset_latency", 64'(lat),         64'd32);
        check_eq("post_reset_div",     {hi_out, lo_out}, 64'h0000_0002_0000_000E);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
